// File: rtl/avgpool2d_bwd_stream_if.sv
// Gradient stream bundle for the backward average pool: dY input stream,
// dX output stream with frame-end marker, and the frame busy flag.
interface avgpool2d_bwd_stream_if #(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic                    busy;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, busy
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/avgpool2d_bwd_stream.sv
// Backward average pool: spreads each scaled dY element over its KxK window,
// producing dX in raster order one row group at a time.
module avgpool2d_bwd_stream #(
  parameter int          CH        = 1,
  parameter int          IN_H      = 2,
  parameter int          IN_W      = 2,
  parameter int          K         = 2,
  parameter int          STRIDE    = 2,
  parameter int          WIDTH     = 16,
  parameter logic [31:0] PRECISION = "Q8.8"
) (
  input logic                  clk,
  input logic                  rst,
  avgpool2d_bwd_stream_if.slave bus
);
  localparam int OUT_H     = (IN_H - K) / STRIDE + 1;
  localparam int OUT_W     = (IN_W - K) / STRIDE + 1;
  localparam int DENOM     = K * K;
  localparam int TAIL_ROWS = IN_H - OUT_H * K;
  localparam bit HAS_TAIL  = (TAIL_ROWS > 0);

  localparam int OW_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int W_W  = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int WI_W = $clog2(IN_W + 1);
  localparam int K_W  = (K > 1) ? $clog2(K) : 1;
  localparam int OH_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [OW_W-1:0] OW_LAST   = OW_W'(OUT_W - 1);
  localparam logic [W_W-1:0]  W_LAST    = W_W'(IN_W - 1);
  localparam logic [WI_W-1:0] WI_OUT    = WI_W'(OUT_W);
  localparam logic [K_W-1:0]  KC_LAST   = K_W'(K - 1);
  localparam logic [K_W-1:0]  TAIL_LAST = K_W'(HAS_TAIL ? TAIL_ROWS - 1 : 0);
  localparam logic [OH_W-1:0] OH_LAST   = OH_W'(OUT_H - 1);
  localparam logic [CH_W-1:0] CH_LAST   = CH_W'(CH - 1);

  localparam logic signed [WIDTH+1:0] DEN_C  = (WIDTH+2)'(DENOM);
  localparam logic signed [WIDTH+1:0] HALF_C = (WIDTH+2)'(DENOM / 2);

  if (STRIDE != K) begin : g_bad_stride
    $error("avgpool2d_bwd_stream: STRIDE must equal K");
  end
  if (PRECISION == '0) begin : g_bad_precision
    $error("avgpool2d_bwd_stream: PRECISION tag must not be empty");
  end

  typedef enum logic [1:0] {LOAD, EMIT, TAIL} state_t;

  state_t          state_reg, state_next;
  logic [OW_W-1:0] ow_reg, ow_next;
  logic [W_W-1:0]  w_reg, w_next;
  logic [K_W-1:0]  kc_reg, kc_next;
  logic [WI_W-1:0] wi_reg, wi_next;
  logic [K_W-1:0]  r_reg, r_next;
  logic [OH_W-1:0] oh_reg, oh_next;
  logic [CH_W-1:0] ch_reg, ch_next;
  logic            busy_reg, busy_next;
  logic            chan_end;

  logic signed [WIDTH-1:0] row_buf [OUT_W];
  logic signed [WIDTH+1:0] g_ext, g_abs, g_mag;
  logic signed [WIDTH-1:0] scaled;

  // Extra two bits keep |-2^(WIDTH-1)| + DENOM/2 representable.
  always_comb begin
    g_ext  = {{2{bus.in_data[WIDTH-1]}}, bus.in_data};
    g_abs  = g_ext[WIDTH+1] ? -g_ext : g_ext;
    g_mag  = (g_abs + HALF_C) / DEN_C;
    scaled = WIDTH'(g_ext[WIDTH+1] ? -g_mag : g_mag);
  end

  always_comb begin
    state_next = state_reg;
    ow_next    = ow_reg;
    w_next     = w_reg;
    kc_next    = kc_reg;
    wi_next    = wi_reg;
    r_next     = r_reg;
    oh_next    = oh_reg;
    ch_next    = ch_reg;
    busy_next  = busy_reg;
    chan_end   = 1'b0;
    case (state_reg)
      LOAD: if (bus.in_valid) begin
        busy_next = 1'b1;
        if (ow_reg == OW_LAST) begin
          ow_next    = '0;
          r_next     = '0;
          w_next     = '0;
          kc_next    = '0;
          wi_next    = '0;
          state_next = EMIT;
        end else begin
          ow_next = ow_reg + 1'b1;
        end
      end
      EMIT: if (bus.out_ready) begin
        if (w_reg == W_LAST) begin
          w_next  = '0;
          kc_next = '0;
          wi_next = '0;
          if (r_reg == KC_LAST) begin
            r_next = '0;
            if (oh_reg == OH_LAST) begin
              oh_next = '0;
              if (HAS_TAIL) state_next = TAIL;
              else          chan_end   = 1'b1;
            end else begin
              oh_next    = oh_reg + 1'b1;
              state_next = LOAD;
            end
          end else begin
            r_next = r_reg + 1'b1;
          end
        end else begin
          w_next = w_reg + 1'b1;
          // kc walks the columns of one window; wi selects the buffered window.
          if (kc_reg == KC_LAST) begin
            kc_next = '0;
            wi_next = wi_reg + 1'b1;
          end else begin
            kc_next = kc_reg + 1'b1;
          end
        end
      end
      TAIL: if (bus.out_ready) begin
        if (w_reg == W_LAST) begin
          w_next = '0;
          if (r_reg == TAIL_LAST) begin
            r_next   = '0;
            chan_end = 1'b1;
          end else begin
            r_next = r_reg + 1'b1;
          end
        end else begin
          w_next = w_reg + 1'b1;
        end
      end
      default: state_next = LOAD;
    endcase
    if (chan_end) begin
      state_next = LOAD;
      if (ch_reg == CH_LAST) begin
        ch_next   = '0;
        busy_next = 1'b0;
      end else begin
        ch_next = ch_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= LOAD;
      ow_reg    <= '0;
      w_reg     <= '0;
      kc_reg    <= '0;
      wi_reg    <= '0;
      r_reg     <= '0;
      oh_reg    <= '0;
      ch_reg    <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ow_reg    <= ow_next;
      w_reg     <= w_next;
      kc_reg    <= kc_next;
      wi_reg    <= wi_next;
      r_reg     <= r_next;
      oh_reg    <= oh_next;
      ch_reg    <= ch_next;
      busy_reg  <= busy_next;
    end
  end

  always_ff @(posedge clk) begin
    if (state_reg == LOAD && bus.in_valid) row_buf[ow_reg] <= scaled;
  end

  always_comb begin
    bus.in_ready  = (state_reg == LOAD);
    bus.out_valid = (state_reg != LOAD);
    bus.busy      = busy_reg;
    bus.out_data  = '0;
    // Columns to the right of the last full window carry no gradient.
    if (state_reg == EMIT && wi_reg < WI_OUT) bus.out_data = row_buf[wi_reg[OW_W-1:0]];
    bus.out_last  = (ch_reg == CH_LAST) && (w_reg == W_LAST) &&
                    ((state_reg == EMIT) ? (!HAS_TAIL && oh_reg == OH_LAST && r_reg == KC_LAST)
                                         : (state_reg == TAIL && r_reg == TAIL_LAST));
  end
endmodule

// File: tb/tb_avgpool2d_bwd_stream.sv
// Directed bench for the backward average pool: four differently sized
// instances share stimulus, and sel picks which one is driven and observed.
module tb_avgpool2d_bwd_stream;
  localparam int P_CH [4] = '{1, 1, 1, 2};
  localparam int P_H  [4] = '{4, 2, 5, 2};
  localparam int P_W  [4] = '{4, 2, 5, 2};

  logic clk = 1'b0;
  logic rst;
  logic [1:0] sel;
  logic signed [15:0] in_data;
  logic in_valid, out_ready;

  logic signed [15:0] o_data [4];
  logic o_valid [4], o_last [4], o_inrdy [4], o_busy [4];

  logic signed [15:0] out_data_o;
  logic out_valid_o, out_last_o, in_ready_o, busy_o;

  int checks = 0;
  int errors = 0;
  int phase = 0;
  bit rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int dy_q [$];
  int dx_q [$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    avgpool2d_bwd_stream_if #(.WIDTH(16)) bus ();
    assign bus.in_data   = in_data;
    assign bus.in_valid  = in_valid && (sel == 2'(gi));
    assign bus.out_ready = out_ready && (sel == 2'(gi));
    assign o_data[gi]    = bus.out_data;
    assign o_valid[gi]   = bus.out_valid;
    assign o_last[gi]    = bus.out_last;
    assign o_inrdy[gi]   = bus.in_ready;
    assign o_busy[gi]    = bus.busy;
    avgpool2d_bwd_stream #(
      .CH(P_CH[gi]), .IN_H(P_H[gi]), .IN_W(P_W[gi]), .K(2), .STRIDE(2), .WIDTH(16)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  assign out_data_o  = o_data[sel];
  assign out_valid_o = o_valid[sel];
  assign out_last_o  = o_last[sel];
  assign in_ready_o  = o_inrdy[sel];
  assign busy_o      = o_busy[sel];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input int v, input string tag);
    int n = 0;
    in_data  = 16'(v);
    in_valid = 1'b1;
    while (!in_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk({tag, " in_ready timeout"}, 32'(in_ready_o), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv(input int exp, input bit exp_last, input bit bp, input string tag);
    int n = 0;
    bit done = 1'b0;
    while (!done) begin
      out_ready = bp ? rdy_pat[phase % 4] : 1'b1;
      phase++;
      if (out_valid_o) begin
        chk({tag, " data"}, out_data_o, exp);
        chk({tag, " last"}, 32'(out_last_o), 32'(exp_last));
        chk({tag, " in_ready"}, 32'(in_ready_o), 0);
        if (out_ready) begin
          chk({tag, " busy"}, 32'(busy_o), 1);
          $display("xfer sel=%0d %s data=%0d last=%0d", sel, tag, out_data_o, out_last_o);
          done = 1'b1;
        end
      end else if (n >= 50) begin
        chk({tag, " out_valid timeout"}, 32'(out_valid_o), 1);
        done = 1'b1;
      end
      n++;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic run_frame(input int s, input int in_per, input int out_per, input bit bp, input string tag);
    int oi = 0;
    sel   = 2'(s);
    phase = 0;
    for (int g = 0; g < dy_q.size() / in_per; g++) begin
      for (int i = 0; i < in_per; i++) send(dy_q[g * in_per + i], tag);
      for (int j = 0; j < out_per; j++) begin
        recv(dx_q[oi], oi == dx_q.size() - 1, bp, $sformatf("%s e%0d", tag, oi + 1));
        oi++;
      end
    end
    while (oi < dx_q.size()) begin
      recv(dx_q[oi], oi == dx_q.size() - 1, bp, $sformatf("%s e%0d", tag, oi + 1));
      oi++;
    end
    chk({tag, " busy after last"}, 32'(busy_o), 0);
    chk({tag, " idle out_valid"}, 32'(out_valid_o), 0);
    chk({tag, " idle in_ready"}, 32'(in_ready_o), 1);
  endtask

  initial begin
    int rv [7] = '{1, 2, 5, 6, -2, -6, -32768};
    int re [7] = '{0, 1, 1, 2, -1, -2, -8192};
    rst = 1'b1; sel = 2'd0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", 32'(in_ready_o), 1);
    chk("reset out_valid", 32'(out_valid_o), 0);
    chk("reset out_last", 32'(out_last_o), 0);
    chk("reset busy", 32'(busy_o), 0);
    chk("reset out_data", out_data_o, 0);

    // 4x4 basic frame
    dy_q = '{4, 8, -4, -6};
    dx_q = '{1, 1, 2, 2, 1, 1, 2, 2, -1, -1, -2, -2, -1, -1, -2, -2};
    run_frame(0, 2, 8, 1'b0, "s1");

    // rounding, one window per frame
    for (int i = 0; i < 7; i++) begin
      dy_q = '{rv[i]};
      dx_q = '{re[i], re[i], re[i], re[i]};
      run_frame(1, 1, 4, 1'b0, $sformatf("s2 dy=%0d", rv[i]));
    end

    // 5x5: uncovered right column and bottom row are zero
    dy_q = '{8, 8, 8, 8};
    dx_q = '{2, 2, 2, 2, 0, 2, 2, 2, 2, 0, 2, 2, 2, 2, 0, 2, 2, 2, 2, 0, 0, 0, 0, 0, 0};
    run_frame(2, 2, 10, 1'b0, "s3");

    // backpressure replay of the 4x4 frame
    dy_q = '{4, 8, -4, -6};
    dx_q = '{1, 1, 2, 2, 1, 1, 2, 2, -1, -1, -2, -2, -1, -1, -2, -2};
    run_frame(0, 2, 8, 1'b1, "s4");

    // two channels
    dy_q = '{12, -12};
    dx_q = '{3, 3, 3, 3, -3, -3, -3, -3};
    run_frame(3, 1, 4, 1'b0, "s5");

    // reset part-way through the first output row
    sel = 2'd0;
    send(4, "s6");
    send(8, "s6");
    recv(1, 1'b0, 1'b0, "s6 pre e1");
    recv(1, 1'b0, 1'b0, "s6 pre e2");
    rst = 1'b1;
    @(negedge clk);
    chk("s6 rst out_valid", 32'(out_valid_o), 0);
    chk("s6 rst in_ready", 32'(in_ready_o), 1);
    chk("s6 rst busy", 32'(busy_o), 0);
    chk("s6 rst out_data", out_data_o, 0);
    rst = 1'b0;
    @(negedge clk);
    dy_q = '{4, 8, -4, -6};
    dx_q = '{1, 1, 2, 2, 1, 1, 2, 2, -1, -1, -2, -2, -1, -1, -2, -2};
    run_frame(0, 2, 8, 1'b0, "s6 replay");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
